// File: rtl/alu_pkg.sv
// Shared CPU constants: opcode classes, ALU operation encodings and flag bit positions.
// Also holds the shifter operation type used by the ALU and its shifter.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  // Instruction classes carried on the opcode bus
  localparam logic [4:0] OPC_ALU_RR    = 5'd0;
  localparam logic [4:0] OPC_ALU_RI    = 5'd1;
  localparam logic [4:0] OPC_LUI       = 5'd2;
  localparam logic [4:0] OPC_MEM_FIRST = 5'd3;
  localparam logic [4:0] OPC_MEM_LAST  = 5'd11;
  localparam logic [4:0] OPC_BR_FIRST  = 5'd12;
  localparam logic [4:0] OPC_BR_LAST   = 5'd14;
  localparam logic [4:0] OPC_PC_ADD    = 5'd22;

  localparam logic [4:0] ALU_AND  = 5'd0;
  localparam logic [4:0] ALU_NAND = 5'd1;
  localparam logic [4:0] ALU_OR   = 5'd2;
  localparam logic [4:0] ALU_NOR  = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_XNOR = 5'd5;
  localparam logic [4:0] ALU_NOT  = 5'd6;
  localparam logic [4:0] ALU_LSL  = 5'd7;
  localparam logic [4:0] ALU_LSR  = 5'd8;
  localparam logic [4:0] ALU_ASR  = 5'd9;
  localparam logic [4:0] ALU_ROTL = 5'd10;
  localparam logic [4:0] ALU_ROTR = 5'd11;
  localparam logic [4:0] ALU_ADD  = 5'd14;
  localparam logic [4:0] ALU_ADDC = 5'd15;
  localparam logic [4:0] ALU_SUB  = 5'd16;
  localparam logic [4:0] ALU_SUBB = 5'd17;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_O = 3;

  typedef enum logic [2:0] {
    SH_LSL,
    SH_LSR,
    SH_ASR,
    SH_ROTL,
    SH_ROTR
  } shift_kind_e;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter/rotator; carry_o is the last bit shifted out (0 for rotates or a zero amount).
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] value_i,
  input  logic [4:0]      amount_i,
  input  shift_kind_e     kind_i,
  output logic [XLEN-1:0] result_o,
  output logic            carry_o
);

  logic [XLEN:0]   lslExt;
  logic [XLEN:0]   lsrExt;
  logic [XLEN:0]   asrExt;
  logic [XLEN-1:0] rotlVal;
  logic [XLEN-1:0] rotrVal;
  logic [5:0]      backAmount;

  // One extra bit on the far side catches the last bit shifted out
  assign lslExt     = {1'b0, value_i} << amount_i;
  assign lsrExt     = {value_i, 1'b0} >> amount_i;
  assign asrExt     = $signed({value_i, 1'b0}) >>> amount_i;
  assign backAmount = 6'd32 - {1'b0, amount_i};
  assign rotlVal    = (value_i << amount_i) | (value_i >> backAmount);
  assign rotrVal    = (value_i >> amount_i) | (value_i << backAmount);

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (kind_i)
      SH_LSL: begin
        result_o = lslExt[XLEN-1:0];
        carry_o  = lslExt[XLEN];
      end
      SH_LSR: begin
        result_o = lsrExt[XLEN:1];
        carry_o  = lsrExt[0];
      end
      SH_ASR: begin
        result_o = asrExt[XLEN:1];
        carry_o  = asrExt[0];
      end
      SH_ROTL: result_o = rotlVal;
      SH_ROTR: result_o = rotrVal;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational result plus a registered C/Z/S/O flag register
// that only ALU-class instructions (or an exception return) may update.
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic [4:0]      opcode,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  input  logic [XLEN-1:0] pc,
  input  logic            bubble_in,
  input  logic [31:0]     flags_restore,
  input  logic            rfe_in_wb,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags
);

  logic [3:0]      flags_q;
  logic [3:0]      flags_d;
  logic [3:0]      newFlags;
  logic [XLEN-1:0] aluResult;
  logic            aluValid;
  logic            aluCarry;
  logic            aluOverflow;
  logic            isAluClass;
  logic            isSub;
  logic [XLEN-1:0] addB;
  logic            addCin;
  logic [XLEN:0]   sum;
  logic            sumOverflow;
  shift_kind_e     shiftKind;
  logic [XLEN-1:0] shiftResult;
  logic            shiftCarry;
  logic            unused_restore;

  assign unused_restore = ^flags_restore[31:4];

  // Subtraction reuses the adder as lhs + ~rhs + cin
  assign isSub       = (alu_op == ALU_SUB) || (alu_op == ALU_SUBB);
  assign addB        = isSub ? ~rhs : rhs;
  assign addCin      = (alu_op == ALU_SUB) ? 1'b1 :
                       (alu_op == ALU_ADD) ? 1'b0 : flags_q[FLAG_C];
  assign sum         = {1'b0, lhs} + {1'b0, addB} + {{XLEN{1'b0}}, addCin};
  assign sumOverflow = (lhs[XLEN-1] == addB[XLEN-1]) && (sum[XLEN-1] != lhs[XLEN-1]);
  assign isAluClass  = (opcode == OPC_ALU_RR) || (opcode == OPC_ALU_RI);

  always_comb begin
    shiftKind = SH_LSL;
    case (alu_op)
      ALU_LSR:  shiftKind = SH_LSR;
      ALU_ASR:  shiftKind = SH_ASR;
      ALU_ROTL: shiftKind = SH_ROTL;
      ALU_ROTR: shiftKind = SH_ROTR;
      default:  shiftKind = SH_LSL;
    endcase
  end

  alu_shifter u_shifter (
    .value_i  (lhs),
    .amount_i (rhs[4:0]),
    .kind_i   (shiftKind),
    .result_o (shiftResult),
    .carry_o  (shiftCarry)
  );

  always_comb begin
    aluResult   = '0;
    aluValid    = 1'b1;
    aluCarry    = 1'b0;
    aluOverflow = 1'b0;
    case (alu_op)
      ALU_AND:  aluResult = lhs & rhs;
      ALU_NAND: aluResult = ~(lhs & rhs);
      ALU_OR:   aluResult = lhs | rhs;
      ALU_NOR:  aluResult = ~(lhs | rhs);
      ALU_XOR:  aluResult = lhs ^ rhs;
      ALU_XNOR: aluResult = ~(lhs ^ rhs);
      ALU_NOT:  aluResult = ~rhs;
      ALU_LSL, ALU_LSR, ALU_ASR, ALU_ROTL, ALU_ROTR: begin
        aluResult = shiftResult;
        aluCarry  = shiftCarry;
      end
      ALU_ADD, ALU_ADDC, ALU_SUB, ALU_SUBB: begin
        aluResult   = sum[XLEN-1:0];
        aluCarry    = sum[XLEN];
        aluOverflow = sumOverflow;
      end
      default: aluValid = 1'b0;
    endcase
  end

  always_comb begin
    result = lhs + rhs;
    if (isAluClass) begin
      result = aluResult;
    end else if (opcode == OPC_LUI) begin
      result = rhs;
    end else if (opcode == OPC_PC_ADD) begin
      result = pc + 32'd4 + rhs;
    end
  end

  // Exception return outranks the instruction in execute
  always_comb begin
    newFlags         = '0;
    newFlags[FLAG_C] = aluCarry;
    newFlags[FLAG_Z] = (aluResult == '0);
    newFlags[FLAG_S] = aluResult[XLEN-1];
    newFlags[FLAG_O] = aluOverflow;
    flags_d          = flags_q;
    if (rfe_in_wb) begin
      flags_d = flags_restore[3:0];
    end else if (!bubble_in && isAluClass && aluValid) begin
      flags_d = newFlags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (clk_en) begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed vector table for the ALU plus hand-written sequences for stall,
// bubble, exception-return and asynchronous-reset behaviour.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [31:0] pc;
  logic        bubble_in;
  logic [31:0] flags_restore;
  logic        rfe_in_wb;
  logic [31:0] result;
  logic [3:0]  flags;

  int checkCount;
  int errorCount;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  aluOp;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] pc;
    logic [31:0] expResult;
    logic [3:0]  expFlags;
  } vector_t;

  localparam int NUM_VEC = 26;
  vector_t vectors [NUM_VEC];

  alu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_en        (clk_en),
    .opcode        (opcode),
    .alu_op        (alu_op),
    .lhs           (lhs),
    .rhs           (rhs),
    .pc            (pc),
    .bubble_in     (bubble_in),
    .flags_restore (flags_restore),
    .rfe_in_wb     (rfe_in_wb),
    .result        (result),
    .flags         (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] opc, input logic [4:0] op,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    @(negedge clk);
    opcode = opc;
    alu_op = op;
    lhs    = a;
    rhs    = b;
    pc     = p;
    #1;
  endtask

  // Flag bit order is {O, S, Z, C}
  initial begin
    vectors[0]  = '{5'd0, 5'd14, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0000_0000, 4'b0011};
    vectors[1]  = '{5'd0, 5'd16, 32'h8000_0000, 32'h0000_0001, 32'h0, 32'h7FFF_FFFF, 4'b1001};
    vectors[2]  = '{5'd0, 5'd7,  32'h8000_0001, 32'h0000_0001, 32'h0, 32'h0000_0002, 4'b0001};
    vectors[3]  = '{5'd2, 5'd0,  32'hDEAD_BEEF, 32'h1234_0000, 32'h0, 32'h1234_0000, 4'b0001};
    vectors[4]  = '{5'd0, 5'd15, 32'h0000_0001, 32'h0000_0001, 32'h0, 32'h0000_0003, 4'b0000};
    vectors[5]  = '{5'd1, 5'd17, 32'h0000_0005, 32'h0000_0003, 32'h0, 32'h0000_0001, 4'b0001};
    vectors[6]  = '{5'd0, 5'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'hF000_F000, 4'b0100};
    vectors[7]  = '{5'd0, 5'd1,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 4'b0010};
    vectors[8]  = '{5'd0, 5'd2,  32'h0000_000F, 32'h0000_00F0, 32'h0, 32'h0000_00FF, 4'b0000};
    vectors[9]  = '{5'd0, 5'd3,  32'h0000_0000, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 4'b0100};
    vectors[10] = '{5'd0, 5'd4,  32'hAAAA_AAAA, 32'h5555_5555, 32'h0, 32'hFFFF_FFFF, 4'b0100};
    vectors[11] = '{5'd0, 5'd5,  32'h1234_5678, 32'h0000_0000, 32'h0, 32'hEDCB_A987, 4'b0100};
    vectors[12] = '{5'd0, 5'd6,  32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 4'b0010};
    vectors[13] = '{5'd0, 5'd8,  32'h0000_0003, 32'h0000_0001, 32'h0, 32'h0000_0001, 4'b0001};
    vectors[14] = '{5'd0, 5'd9,  32'h8000_0000, 32'h0000_0004, 32'h0, 32'hF800_0000, 4'b0100};
    vectors[15] = '{5'd0, 5'd9,  32'h8000_0010, 32'h0000_0020, 32'h0, 32'h8000_0010, 4'b0100};
    vectors[16] = '{5'd0, 5'd10, 32'h8000_0001, 32'h0000_0004, 32'h0, 32'h0000_0018, 4'b0000};
    vectors[17] = '{5'd0, 5'd11, 32'h0000_0001, 32'h0000_0001, 32'h0, 32'h8000_0000, 4'b0100};
    vectors[18] = '{5'd0, 5'd12, 32'h0000_0001, 32'h0000_0001, 32'h0, 32'h0000_0000, 4'b0100};
    vectors[19] = '{5'd1, 5'd14, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 32'h8000_0000, 4'b1100};
    vectors[20] = '{5'd22, 5'd14, 32'hFFFF_0000, 32'h0000_0008, 32'h100, 32'h0000_010C, 4'b1100};
    vectors[21] = '{5'd5, 5'd16, 32'h0000_1000, 32'h0000_0020, 32'h0, 32'h0000_1020, 4'b1100};
    vectors[22] = '{5'd12, 5'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0000_0001, 4'b1100};
    vectors[23] = '{5'd0, 5'd7,  32'h0000_0003, 32'h0000_001F, 32'h0, 32'h8000_0000, 4'b0101};
    vectors[24] = '{5'd0, 5'd8,  32'h8000_0000, 32'h0000_001F, 32'h0, 32'h0000_0001, 4'b0000};
    vectors[25] = '{5'd0, 5'd16, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'hFFFF_FFFE, 4'b0100};

    checkCount    = 0;
    errorCount    = 0;
    rst_n         = 1'b0;
    clk_en        = 1'b1;
    opcode        = 5'd0;
    alu_op        = 5'd0;
    lhs           = 32'h0;
    rhs           = 32'h0;
    pc            = 32'h0;
    bubble_in     = 1'b0;
    flags_restore = 32'h0;
    rfe_in_wb     = 1'b0;

    #12;
    checkOutput("reset_flags", {28'h0, flags}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vectors[i].opcode, vectors[i].aluOp, vectors[i].lhs, vectors[i].rhs, vectors[i].pc);
      checkOutput($sformatf("vec%0d_result", i), result, vectors[i].expResult);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_flags", i), {28'h0, flags}, {28'h0, vectors[i].expFlags});
    end

    // Flags are 0100 here; a bubble must not commit the add's 0011
    bubble_in = 1'b1;
    applyStimulus(5'd0, 5'd14, 32'hFFFF_FFFF, 32'h1, 32'h0);
    checkOutput("bubble_result", result, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("bubble_flags", {28'h0, flags}, 32'h4);
    bubble_in = 1'b0;

    clk_en        = 1'b0;
    rfe_in_wb     = 1'b1;
    flags_restore = 32'hFFFF_FFF3;
    applyStimulus(5'd0, 5'd14, 32'hFFFF_FFFF, 32'h1, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("stall_flags", {28'h0, flags}, 32'h4);
    clk_en        = 1'b1;

    flags_restore = 32'hFFFF_FFFA;
    applyStimulus(5'd0, 5'd14, 32'hFFFF_FFFF, 32'h1, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rfe_flags", {28'h0, flags}, 32'hA);
    rfe_in_wb = 1'b0;

    // Commit nonzero flags, then pull reset between edges
    applyStimulus(5'd0, 5'd14, 32'hFFFF_FFFF, 32'h1, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_flags", {28'h0, flags}, 32'h3);
    #1;
    rst_n = 1'b0;
    opcode = 5'd22;
    pc     = 32'h100;
    rhs    = 32'h8;
    #1;
    checkOutput("async_reset_flags", {28'h0, flags}, 32'h0);
    checkOutput("reset_result", result, 32'h10C);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
